// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use / control stalls held for a
// configurable number of cycles, memory freeze, EX flush, stall counter.
module hazard_ctrl_unit #(
    parameter int REG_IDX_W         = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CTRL_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_reg1_idx,
    input  logic [REG_IDX_W-1:0] id_reg2_idx,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic                 id_is_ctrl,
    input  logic [REG_IDX_W-1:0] ex_reg_wr_idx,
    input  logic                 ex_do_mem_read_en,
    input  logic                 ex_flush,
    input  logic                 mem_busy,
    output logic                 hazard_fe_enable,
    output logic                 hazard_if_id_clear,
    output logic                 hazard_id_ex_clear,
    output logic                 hazard_busy,
    output logic [CNT_W-1:0]     stall_cycles
);

    localparam int MAX_STALL = (LOAD_STALL_CYCLES > CTRL_STALL_CYCLES) ?
                               LOAD_STALL_CYCLES : CTRL_STALL_CYCLES;
    localparam int WAIT_W = $clog2(MAX_STALL + 1);

    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] LOAD_INIT = WAIT_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [WAIT_W-1:0] CTRL_INIT = WAIT_W'(CTRL_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        CTRL_WAIT  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic                load_use;
    logic                rs1_hit, rs2_hit;

    assign rs1_hit  = id_uses_rs1 && (id_reg1_idx == ex_reg_wr_idx);
    assign rs2_hit  = id_uses_rs2 && (id_reg2_idx == ex_reg_wr_idx);
    assign load_use = ex_do_mem_read_en && (ex_reg_wr_idx != '0) &&
                      (rs1_hit || rs2_hit);

    // Next state and stall/bubble outputs; flush beats freeze beats FSM
    always_comb begin
        state_d            = state_q;
        wait_d             = wait_q;
        hazard_fe_enable   = 1'b1;
        hazard_if_id_clear = 1'b0;
        hazard_id_ex_clear = 1'b0;
        if (!rst) begin
            if (ex_flush) begin
                hazard_if_id_clear = 1'b1;
                hazard_id_ex_clear = 1'b1;
                state_d            = RUN;
                wait_d             = '0;
            end else if (mem_busy) begin
                hazard_fe_enable = 1'b0;
            end else begin
                unique case (state_q)
                    RUN: begin
                        if (load_use) begin
                            hazard_fe_enable   = 1'b0;
                            hazard_id_ex_clear = 1'b1;
                            if (LOAD_STALL_CYCLES > 1) begin
                                state_d = LOAD_STALL;
                                wait_d  = LOAD_INIT;
                            end
                        end else if (id_is_ctrl) begin
                            hazard_fe_enable   = 1'b0;
                            hazard_if_id_clear = 1'b1;
                            if (CTRL_STALL_CYCLES > 1) begin
                                state_d = CTRL_WAIT;
                                wait_d  = CTRL_INIT;
                            end
                        end
                    end
                    LOAD_STALL: begin
                        hazard_fe_enable   = 1'b0;
                        hazard_id_ex_clear = 1'b1;
                        wait_d             = wait_q - WAIT_ONE;
                        if (wait_q == WAIT_ONE) begin
                            state_d = RUN;
                        end
                    end
                    CTRL_WAIT: begin
                        hazard_fe_enable   = 1'b0;
                        hazard_if_id_clear = 1'b1;
                        wait_d             = wait_q - WAIT_ONE;
                        if (wait_q == WAIT_ONE) begin
                            state_d = RUN;
                        end
                    end
                    default: begin
                        state_d = RUN;
                        wait_d  = '0;
                    end
                endcase
            end
        end
    end

    // Saturating count of frozen-fetch cycles
    always_comb begin
        stall_d = stall_q;
        if (!hazard_fe_enable && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // State, wait counter and perf counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            wait_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
        end
    end

    assign hazard_busy  = !rst && (state_q != RUN);
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: default instance and a multi-cycle instance
// (LOAD=3, CTRL=2, CNT_W=4) checked against a stall-budget model.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b1;
    logic       rst = 1'b1;
    logic [4:0] r1 = '0, r2 = '0, wr = '0;
    logic       u1 = 1'b0, u2 = 1'b0, ctrl = 1'b0;
    logic       ld = 1'b0, flush = 1'b0, mbusy = 1'b0;

    logic        fe_a, ifc_a, exc_a, bsy_a;
    logic [15:0] sc_a;
    logic        fe_b, ifc_b, exc_b, bsy_b;
    logic [3:0]  sc_b;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    hazard_ctrl_unit u_a (
        .clk(clk), .rst(rst),
        .id_reg1_idx(r1), .id_reg2_idx(r2),
        .id_uses_rs1(u1), .id_uses_rs2(u2), .id_is_ctrl(ctrl),
        .ex_reg_wr_idx(wr), .ex_do_mem_read_en(ld),
        .ex_flush(flush), .mem_busy(mbusy),
        .hazard_fe_enable(fe_a), .hazard_if_id_clear(ifc_a),
        .hazard_id_ex_clear(exc_a), .hazard_busy(bsy_a),
        .stall_cycles(sc_a)
    );

    hazard_ctrl_unit #(
        .REG_IDX_W(5), .LOAD_STALL_CYCLES(3),
        .CTRL_STALL_CYCLES(2), .CNT_W(4)
    ) u_b (
        .clk(clk), .rst(rst),
        .id_reg1_idx(r1), .id_reg2_idx(r2),
        .id_uses_rs1(u1), .id_uses_rs2(u2), .id_is_ctrl(ctrl),
        .ex_reg_wr_idx(wr), .ex_do_mem_read_en(ld),
        .ex_flush(flush), .mem_busy(mbusy),
        .hazard_fe_enable(fe_b), .hazard_if_id_clear(ifc_b),
        .hazard_id_ex_clear(exc_b), .hazard_busy(bsy_b),
        .stall_cycles(sc_b)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Model: each hazard owns a budget of frozen cycles; "left" is how many
    // of them remain after the current one, and the kind picks the bubble.
    int left[2] = '{0, 0};
    bit kind_ld[2] = '{1'b0, 1'b0};
    int exp_sc[2] = '{0, 0};

    always @(negedge clk) begin : cmp
        int  ls, cs, smax, nleft;
        bit  nld, lu, efe, eif, eex, ebs;
        logic gfe, gif, gex, gbs;
        logic [31:0] gsc;
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                ls   = (i == 0) ? 1 : 3;
                cs   = (i == 0) ? 1 : 2;
                smax = (i == 0) ? 65535 : 15;
                lu = ld && (wr != 0) &&
                     ((u1 && r1 == wr) || (u2 && r2 == wr));
                nleft = left[i];
                nld   = kind_ld[i];
                efe = 1; eif = 0; eex = 0;
                ebs = (left[i] > 0);
                if (rst) begin
                    ebs = 0; nleft = 0; exp_sc[i] = 0;
                end else if (flush) begin
                    eif = 1; eex = 1; nleft = 0;
                end else if (mbusy) begin
                    efe = 0;
                end else if (left[i] > 0) begin
                    efe = 0;
                    if (kind_ld[i]) eex = 1;
                    else eif = 1;
                    nleft = left[i] - 1;
                end else if (lu) begin
                    efe = 0; eex = 1; nleft = ls - 1; nld = 1;
                end else if (ctrl) begin
                    efe = 0; eif = 1; nleft = cs - 1; nld = 0;
                end
                gfe = (i == 0) ? fe_a : fe_b;
                gif = (i == 0) ? ifc_a : ifc_b;
                gex = (i == 0) ? exc_a : exc_b;
                gbs = (i == 0) ? bsy_a : bsy_b;
                gsc = (i == 0) ? 32'(sc_a) : 32'(sc_b);
                chk($sformatf("m%0d.fe_enable", i), 32'(gfe), 32'(efe));
                chk($sformatf("m%0d.if_id_clear", i), 32'(gif), 32'(eif));
                chk($sformatf("m%0d.id_ex_clear", i), 32'(gex), 32'(eex));
                chk($sformatf("m%0d.busy", i), 32'(gbs), 32'(ebs));
                chk($sformatf("m%0d.stall_cycles", i), gsc, exp_sc[i]);
                if (!rst && !efe && exp_sc[i] < smax) exp_sc[i]++;
                left[i]    = nleft;
                kind_ld[i] = nld;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic nop;
        r1 = 5'd1; r2 = 5'd2; u1 = 1; u2 = 1; wr = 5'd3;
        ld = 0; ctrl = 0; flush = 0; mbusy = 0;
    endtask

    task automatic load_use5;
        r1 = 5'd5; u1 = 1; u2 = 0; wr = 5'd5; ld = 1; ctrl = 0;
    endtask

    task automatic lit_b(input string nm, input bit fe, input bit ifc,
                         input bit exc, input bit bsy);
        #1;
        chk({nm, ".fe"}, 32'(fe_b), 32'(fe));
        chk({nm, ".ifid"}, 32'(ifc_b), 32'(ifc));
        chk({nm, ".idex"}, 32'(exc_b), 32'(exc));
        chk({nm, ".busy"}, 32'(bsy_b), 32'(bsy));
    endtask

    initial begin
        tick;
        started = 1'b1;
        tick;
        rst = 0;
        nop;
        lit_b("reset_out", 1, 0, 0, 0);
        chk("reset_sc_b", 32'(sc_b), 0);
        repeat (3) tick;
        chk("add_fe_a", 32'(fe_a), 1);
        chk("add_sc_a", 32'(sc_a), 0);

        load_use5;
        lit_b("lu_c1", 0, 0, 1, 0);
        tick; nop;
        lit_b("lu_c2", 0, 0, 1, 1);
        tick;
        lit_b("lu_c3", 0, 0, 1, 1);
        tick;
        lit_b("lu_done", 1, 0, 0, 0);
        chk("lu_sc_b", 32'(sc_b), 3);
        chk("lu_sc_a", 32'(sc_a), 1);

        r1 = 5'd0; u1 = 1; u2 = 0; wr = 5'd0; ld = 1;
        lit_b("idx0", 1, 0, 0, 0);
        tick;
        r1 = 5'd5; u1 = 0; u2 = 0; wr = 5'd5; ld = 1;
        lit_b("no_use", 1, 0, 0, 0);
        tick; nop;

        ctrl = 1;
        lit_b("ctrl_c1", 0, 1, 0, 0);
        tick; ctrl = 0;
        lit_b("ctrl_c2", 0, 1, 0, 1);
        tick;
        lit_b("ctrl_done", 1, 0, 0, 0);
        load_use5; ctrl = 1;
        lit_b("lu_over_ctrl", 0, 0, 1, 0);
        tick; nop;
        repeat (2) tick;

        load_use5;
        tick; nop; mbusy = 1;
        for (int k = 0; k < 4; k++) begin
            lit_b("freeze", 0, 0, 0, 1);
            tick;
        end
        mbusy = 0;
        lit_b("thaw_c1", 0, 0, 1, 1);
        tick;
        lit_b("thaw_c2", 0, 0, 1, 1);
        tick;
        lit_b("thaw_done", 1, 0, 0, 0);

        ctrl = 1;
        tick; ctrl = 0; flush = 1;
        lit_b("flush", 1, 1, 1, 1);
        tick; flush = 0;
        lit_b("post_flush", 1, 0, 0, 0);

        load_use5;
        tick; nop;
        lit_b("pre_rst", 0, 0, 1, 1);
        rst = 1;
        lit_b("mid_rst", 1, 0, 0, 0);
        chk("rst_sc_b", 32'(sc_b), 0);
        chk("rst_sc_a", 32'(sc_a), 0);
        tick; rst = 0;

        mbusy = 1;
        repeat (20) tick;
        chk("sat_sc_b", 32'(sc_b), 15);
        chk("sat_sc_a", 32'(sc_a), 20);
        mbusy = 0;
        tick;
        chk("sat_hold_b", 32'(sc_b), 15);
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
